pll_reconfig_sequencer: RTL

Parametrised successor to the video-clock bring-up logic: accepts runtime divider configs (from the SPI command processor), encodes them to rPLL dsel form, pulses PLL reset, waits for lock with timeout/retry, and gates a downstream domain reset until lock is stable. Adds validation, lock-loss recovery and failure reporting. Sits in the system clock domain beside the video rPLL.

---
 rtl/pll_reconfig_pkg.sv | 42 ++++
 rtl/pll_reconfig_sequencer_sync_ff.sv | 23 ++
 rtl/pll_reconfig_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pll_reconfig_pkg.sv
// Shared types and helpers for the video rPLL reconfiguration sequencer:
// sequencer states, the requested divider triple, and the dsel encoding and
// validity rules used by the rPLL.
package pll_reconfig_pkg;

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT_LOCK,
    S_SETTLE,
    S_RUN,
    S_FAIL
  } seq_state_t;

  // Divider triple, widened to 32 bits so the helpers work for any DIV_W <= 32
  typedef struct packed {
    logic [31:0] fb_div;
    logic [31:0] in_div;
    logic [31:0] out_div;
  } div_cfg_t;

  // rPLL dsel form is 2^dsel_w - divider; callers truncate to dsel_w bits
  function automatic logic [31:0] encode_div(input logic [31:0] div, input int dsel_w);
    logic [31:0] full;
    full = 32'd1 << dsel_w;
    return full - div;
  endfunction

  // The output divider is programmed as half its value
  function automatic logic [31:0] encode_out(input logic [31:0] div, input int dsel_w);
    return encode_div(div >> 1, dsel_w);
  endfunction

  // Dividers must lie in the range the rPLL can actually express
  function automatic logic cfg_is_valid(input div_cfg_t cfg, input int dsel_w);
    logic [31:0] lim;
    lim = 32'd1 << dsel_w;
    return (cfg.fb_div != 32'd0) && (cfg.fb_div <= lim) &&
           (cfg.in_div != 32'd0) && (cfg.in_div <= lim) &&
           !cfg.out_div[0] && (cfg.out_div >= 32'd2) && (cfg.out_div <= (lim << 1));
  endfunction

endpackage

// File: rtl/pll_reconfig_sequencer_sync_ff.sv
// Two-flop synchroniser bringing the asynchronous rPLL lock into the system
// clock domain. Resets to 0 so a stale lock is never trusted after reset.
module sync_ff (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; q is two clocks behind d
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reconfig_sequencer.sv
// Video rPLL reconfiguration sequencer: accepts divider configs, encodes them
// to dsel form, pulses the PLL reset, waits for lock with timeout and retry,
// and holds the PLL-clocked domain in reset until lock has been stable.
// Optional feature macro: PLL_RECONFIG_STATUS_EN adds lock_loss_count and
// retry_count status outputs.
module pll_reconfig_sequencer
  import pll_reconfig_pkg::*;
#(
  parameter int DSEL_W        = 6,
  parameter int DIV_W         = 16,
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int SETTLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 3,
  parameter int DEF_FB        = 4,
  parameter int DEF_IN        = 4,
  parameter int DEF_OUT       = 8,
  localparam int RETRY_W      = (MAX_RETRY < 3) ? 2 : $clog2(MAX_RETRY + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DIV_W-1:0]  cfg_input_divider,
  input  logic [DIV_W-1:0]  cfg_feedback_divider,
  input  logic [DIV_W-1:0]  cfg_output_divider,
  input  logic              pll_lock,
  output logic              pll_reset,
  output logic [DSEL_W-1:0] pll_fbdsel,
  output logic [DSEL_W-1:0] pll_idsel,
  output logic [DSEL_W-1:0] pll_odsel,
  output logic              domain_reset,
  output logic              busy,
  output logic              cfg_error,
  output logic              fail
`ifdef PLL_RECONFIG_STATUS_EN
  ,
  output logic [7:0]        lock_loss_count,
  output logic [RETRY_W-1:0] retry_count
`endif
);

  localparam int CNT_MAX_A = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > SETTLE_CYCLES) ? CNT_MAX_A : SETTLE_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);

  localparam logic [DSEL_W-1:0] DEF_FB_ENC  = DSEL_W'(encode_div(32'(DEF_FB), DSEL_W));
  localparam logic [DSEL_W-1:0] DEF_IN_ENC  = DSEL_W'(encode_div(32'(DEF_IN), DSEL_W));
  localparam logic [DSEL_W-1:0] DEF_OUT_ENC = DSEL_W'(encode_out(32'(DEF_OUT), DSEL_W));

  seq_state_t         state;
  logic [CNT_W-1:0]   cnt;
  logic [RETRY_W-1:0] retry;
  logic               lock_s;
  div_cfg_t           cfg_req;
  logic               cfg_fire;
  logic               cfg_ok;
  logic [DSEL_W-1:0]  enc_fb;
  logic [DSEL_W-1:0]  enc_in;
  logic [DSEL_W-1:0]  enc_out;

  sync_ff u_lock_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (pll_lock),
    .q       (lock_s)
  );

  // Widen the offered dividers and pre-compute their validity and encoding
  always_comb begin
    cfg_req = '0;
    cfg_req.fb_div[DIV_W-1:0]  = cfg_feedback_divider;
    cfg_req.in_div[DIV_W-1:0]  = cfg_input_divider;
    cfg_req.out_div[DIV_W-1:0] = cfg_output_divider;
  end

  assign cfg_ok    = cfg_is_valid(cfg_req, DSEL_W);
  assign enc_fb    = DSEL_W'(encode_div(cfg_req.fb_div, DSEL_W));
  assign enc_in    = DSEL_W'(encode_div(cfg_req.in_div, DSEL_W));
  assign enc_out   = DSEL_W'(encode_out(cfg_req.out_div, DSEL_W));
  assign cfg_ready = (state != S_RESET);
  assign cfg_fire  = cfg_valid && cfg_ready;

  // Sequencer FSM; a valid config outranks every lock/timeout event
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_RESET;
      cnt          <= '0;
      retry        <= '0;
      pll_reset    <= 1'b1;
      domain_reset <= 1'b1;
      busy         <= 1'b1;
      fail         <= 1'b0;
      cfg_error    <= 1'b0;
      pll_fbdsel   <= DEF_FB_ENC;
      pll_idsel    <= DEF_IN_ENC;
      pll_odsel    <= DEF_OUT_ENC;
    end else begin
      cfg_error <= 1'b0;
      if (cfg_fire && cfg_ok) begin
        pll_fbdsel   <= enc_fb;
        pll_idsel    <= enc_in;
        pll_odsel    <= enc_out;
        retry        <= '0;
        fail         <= 1'b0;
        state        <= S_RESET;
        cnt          <= '0;
        pll_reset    <= 1'b1;
        domain_reset <= 1'b1;
        busy         <= 1'b1;
      end else begin
        if (cfg_fire) begin
          cfg_error <= 1'b1;
        end
        unique case (state)
          S_RESET: begin
            if (cnt == RESET_LAST) begin
              state     <= S_WAIT_LOCK;
              cnt       <= '0;
              pll_reset <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_WAIT_LOCK: begin
            if (lock_s) begin
              if (SETTLE_CYCLES <= 1) begin
                state        <= S_RUN;
                cnt          <= '0;
                domain_reset <= 1'b0;
                busy         <= 1'b0;
              end else begin
                state <= S_SETTLE;
                cnt   <= CNT_W'(1);
              end
            end else if (cnt == TIMEOUT_LAST) begin
              cnt <= '0;
              if (retry < RETRY_MAX) begin
                retry     <= retry + RETRY_W'(1);
                state     <= S_RESET;
                pll_reset <= 1'b1;
              end else begin
                state <= S_FAIL;
                fail  <= 1'b1;
                busy  <= 1'b0;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_SETTLE: begin
            if (!lock_s) begin
              state <= S_WAIT_LOCK;
              cnt   <= '0;
            end else if (cnt == SETTLE_LAST) begin
              state        <= S_RUN;
              cnt          <= '0;
              domain_reset <= 1'b0;
              busy         <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_RUN: begin
            if (!lock_s) begin
              state        <= S_WAIT_LOCK;
              cnt          <= '0;
              domain_reset <= 1'b1;
              busy         <= 1'b1;
            end
          end
          S_FAIL: begin
            pll_reset    <= 1'b0;
            domain_reset <= 1'b1;
            busy         <= 1'b0;
            fail         <= 1'b1;
          end
          default: begin
            state <= S_RESET;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

`ifdef PLL_RECONFIG_STATUS_EN
  logic run_lost;
  assign run_lost    = (state == S_RUN) && !lock_s && !(cfg_fire && cfg_ok);
  assign retry_count = retry;

  // Saturating count of lock losses while running; only reset_n clears it
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_loss_count <= '0;
    end else if (run_lost && (lock_loss_count != 8'hFF)) begin
      lock_loss_count <= lock_loss_count + 8'd1;
    end
  end
`endif

endmodule
